// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: sequencing stage around an external combinational 32x32
// unsigned multiplier. It registers the operands and waits a fixed settle
// latency. For signed MULT it multiplies the magnitudes and negates the
// 64-bit product. It owns the architectural HI/LO pair and stalls the
// pipeline while a multiply is in flight.
module hilo_mul_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        op_ready,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    // The WAIT countdown starts at MUL_LAT-1, so WAIT lasts MUL_LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_d, lo_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        legal_op;
    logic        is_mul;

    // Two's-complement magnitude. 0x80000000 maps to itself and is then
    // read as unsigned 2^31 by the multiplier.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    // Restores the sign of a signed product formed from magnitudes.
    function automatic logic [63:0] fix_sign(input logic [63:0] p, input logic neg);
        return neg ? (~p + 64'd1) : p;
    endfunction

    assign legal_op = op_valid && (op != 3'b000) && (op != 3'b111);
    assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);

    // State register and all architectural/datapath flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            neg_q      <= 1'b0;
            mul_a_q    <= 32'd0;
            mul_b_q    <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next state: a multiply moves to WAIT and returns once the count expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (legal_op && is_mul) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs derived from the current state.
    always_comb begin
        op_ready = (state_q == ST_IDLE);
        busy     = (state_q == ST_WAIT);
        stall    = legal_op && (state_q != ST_IDLE);
    end

    // Datapath: accept ops in IDLE, and count down and capture the product in WAIT.
    always_comb begin
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (legal_op) begin
                case (op)
                    OP_MULT: begin
                        mul_a_d = abs32(rs_data);
                        mul_b_d = abs32(rt_data);
                        neg_d   = rs_data[31] ^ rt_data[31];
                        cnt_d   = CNT_INIT;
                    end
                    OP_MULTU: begin
                        mul_a_d = rs_data;
                        mul_b_d = rt_data;
                        neg_d   = 1'b0;
                        cnt_d   = CNT_INIT;
                    end
                    OP_MTHI: hi_d = rs_data;
                    OP_MTLO: lo_d = rs_data;
                    OP_MFHI: begin
                        rd_data_d  = hi_q;
                        rd_valid_d = 1'b1;
                    end
                    OP_MFLO: begin
                        rd_data_d  = lo_q;
                        rd_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                {hi_d, lo_d} = fix_sign({mul_hi, mul_lo}, neg_q);
            end
        end
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Bench for hilo_mul_ctrl: directed HI/LO instruction sequences. An
// arithmetic reference model is compared on every falling edge, and literal
// expectations pin the key results.
module tb_hilo_mul_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic [31:0] mul_a, mul_b, mul_hi, mul_lo;
    logic        op_ready, stall, busy, rd_valid;
    logic [31:0] rd_data, hi_q, lo_q;

    int n_cmp = 0;
    int n_err = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    // The external unsigned multiplier that the block drives.
    assign {mul_hi, mul_lo} = {32'd0, mul_a} * {32'd0, mul_b};

    hilo_mul_ctrl #(.MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mul_a(mul_a), .mul_b(mul_b),
        .mul_hi(mul_hi), .mul_lo(mul_lo), .op_ready(op_ready), .stall(stall),
        .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .hi_q(hi_q), .lo_q(lo_q)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: HI/LO, the cycles left before the result lands, and the
    // final signed or unsigned product computed directly.
    logic [31:0] m_hi, m_lo, m_a, m_b, m_rd;
    logic [63:0] m_prod;
    logic        m_rdv;
    int          m_left;

    function automatic logic [31:0] mag(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        return v[31:0];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_rd = 0; m_rdv = 0;
            m_prod = 0; m_left = 0;
        end else begin
            m_rdv = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) {m_hi, m_lo} = m_prod;
            end else if (op_valid && op != 3'd0 && op != 3'd7) begin
                case (op)
                    3'd1: begin
                        m_prod = longint'($signed(rs_data)) * longint'($signed(rt_data));
                        m_a = mag(rs_data); m_b = mag(rt_data); m_left = LAT;
                    end
                    3'd2: begin
                        m_prod = {32'd0, rs_data} * {32'd0, rt_data};
                        m_a = rs_data; m_b = rt_data; m_left = LAT;
                    end
                    3'd3: m_hi = rs_data;
                    3'd4: m_lo = rs_data;
                    3'd5: begin m_rd = m_hi; m_rdv = 1'b1; end
                    3'd6: begin m_rd = m_lo; m_rdv = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (run_cmp && reset) begin
            check("busy", busy, m_left > 0);
            check("op_ready", op_ready, m_left == 0);
            check("stall", stall, op_valid && op != 3'd0 && op != 3'd7 && m_left > 0);
            check("hi_q", hi_q, m_hi);
            check("lo_q", lo_q, m_lo);
            check("rd_valid", rd_valid, m_rdv);
            check("rd_data", rd_data, m_rd);
            check("mul_a", mul_a, m_a);
            check("mul_b", mul_b, m_b);
        end
    end

    // Present an op starting now (just after a rising edge) and hold it until accepted.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            check("issue_timeout", op_ready, 1'b1);
        end
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi_q, 32'd0);
        check("rst_lo", lo_q, 32'd0);
        check("rst_rdv", rd_valid, 1'b0);
        check("rst_ready", op_ready, 1'b1);
        reset = 1'b1;
        run_cmp = 1'b1;
        realign();

        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_busy", busy, 1'b1);
        wait_idle();
        check("multu_hi", hi_q, 32'hFFFFFFFE);
        check("multu_lo", lo_q, 32'h00000001);
        realign();

        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        check("mult_a", mul_a, 32'd2);
        check("mult_b", mul_b, 32'd3);
        wait_idle();
        check("mult_n2x3_hi", hi_q, 32'hFFFFFFFF);
        check("mult_n2x3_lo", lo_q, 32'hFFFFFFFA);
        realign();

        issue(3'd1, -32'sd7, -32'sd6);
        wait_idle();
        check("mult_n7xn6_hi", hi_q, 32'd0);
        check("mult_n7xn6_lo", lo_q, 32'h2A);
        realign();

        issue(3'd1, 32'h80000000, 32'h80000000);
        wait_idle();
        check("mult_min2_hi", hi_q, 32'h40000000);
        check("mult_min2_lo", lo_q, 32'd0);
        realign();

        issue(3'd1, 32'h80000000, 32'd1);
        wait_idle();
        check("mult_minx1_hi", hi_q, 32'hFFFFFFFF);
        check("mult_minx1_lo", lo_q, 32'h80000000);
        realign();

        // MFLO follows immediately and must stall until the product lands.
        issue(3'd1, 32'd5, 32'd7);
        issue(3'd6, 32'd0, 32'd0);
        check("mflo_valid", rd_valid, 1'b1);
        check("mflo_data", rd_data, 32'h23);

        issue(3'd3, 32'h12345678, 32'd0);
        issue(3'd5, 32'd0, 32'd0);
        check("mfhi_valid", rd_valid, 1'b1);
        check("mfhi_data", rd_data, 32'h12345678);
        check("mthi_lo_kept", lo_q, 32'h23);
        realign();
        check("mfhi_pulse", rd_valid, 1'b0);

        op_valid = 1'b1; op = 3'd7; rs_data = 32'hDEADBEEF;
        @(negedge clk);
        check("resv_stall", stall, 1'b0);
        realign();
        op_valid = 1'b0; op = 3'd0;
        @(negedge clk);
        check("resv_hi", hi_q, 32'h12345678);
        realign();

        issue(3'd2, 32'd3, 32'd4);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_hi", hi_q, 32'd0);
        check("arst_lo", lo_q, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        realign();
        issue(3'd2, 32'd3, 32'd4);
        wait_idle();
        check("after_rst_lo", lo_q, 32'd12);
        check("after_rst_hi", hi_q, 32'd0);
        realign();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
